// File: rtl/punc_control_if.sv
// ============================================================================
//  punc_control_if : control/status bundle between the PUnC controller and
//  its datapath. Revision: 1.0
// ============================================================================
`default_nettype none

interface punc_control_if;
  logic [15:0] ir;
  logic        n;
  logic        z;
  logic        p;
  logic        mem_w_en;
  logic [1:0]  mem_w_addr_sel;
  logic        mem_w_data_sel;
  logic [1:0]  mem_r_addr_sel;
  logic        rf_w_en;
  logic        rf_r0_addr_sel;
  logic        rf_r1_addr_sel;
  logic [1:0]  rf_w_data_sel;
  logic        rf_w_addr_sel;
  logic        ir_ld;
  logic        pc_ld;
  logic        pc_clr;
  logic        pc_inc;
  logic [1:0]  pc_ld_data_sel;
  logic [2:0]  alu_sel;
  logic        cond_ld;
  logic        cond_ld_data_sel;
  logic        ldi_reg_ld;
  logic        halted;

  // Controller side
  modport master (
    input  ir, n, z, p,
    output mem_w_en, mem_w_addr_sel, mem_w_data_sel, mem_r_addr_sel,
           rf_w_en, rf_r0_addr_sel, rf_r1_addr_sel, rf_w_data_sel, rf_w_addr_sel,
           ir_ld, pc_ld, pc_clr, pc_inc, pc_ld_data_sel, alu_sel,
           cond_ld, cond_ld_data_sel, ldi_reg_ld, halted
  );

  // Datapath side
  modport slave (
    output ir, n, z, p,
    input  mem_w_en, mem_w_addr_sel, mem_w_data_sel, mem_r_addr_sel,
           rf_w_en, rf_r0_addr_sel, rf_r1_addr_sel, rf_w_data_sel, rf_w_addr_sel,
           ir_ld, pc_ld, pc_clr, pc_inc, pc_ld_data_sel, alu_sel,
           cond_ld, cond_ld_data_sel, ldi_reg_ld, halted
  );
endinterface

`default_nettype wire

// File: rtl/punc_control.sv
// ============================================================================
//  punc_control : LC3 (PUnC) control FSM, outputs decoded from state and IR.
//  Optional macro PUNC_CTRL_PERF_EN adds the instr_retired counter port.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module punc_control #(
  parameter logic [3:0] HALT_OPCODE = 4'b1111
) (
  input  logic              clk,
  input  logic              rst,
  punc_control_if.master    bus
`ifdef PUNC_CTRL_PERF_EN
  ,
  output logic [15:0]       instr_retired
`endif
);

  localparam logic [3:0] c_OP_BR  = 4'b0000;
  localparam logic [3:0] c_OP_ADD = 4'b0001;
  localparam logic [3:0] c_OP_LD  = 4'b0010;
  localparam logic [3:0] c_OP_ST  = 4'b0011;
  localparam logic [3:0] c_OP_JSR = 4'b0100;
  localparam logic [3:0] c_OP_AND = 4'b0101;
  localparam logic [3:0] c_OP_LDR = 4'b0110;
  localparam logic [3:0] c_OP_STR = 4'b0111;
  localparam logic [3:0] c_OP_NOT = 4'b1001;
  localparam logic [3:0] c_OP_LDI = 4'b1010;
  localparam logic [3:0] c_OP_STI = 4'b1011;
  localparam logic [3:0] c_OP_JMP = 4'b1100;
  localparam logic [3:0] c_OP_LEA = 4'b1110;

  localparam logic [2:0] c_ALU_ADD  = 3'd0;
  localparam logic [2:0] c_ALU_ADDI = 3'd1;
  localparam logic [2:0] c_ALU_NOT  = 3'd2;
  localparam logic [2:0] c_ALU_AND  = 3'd3;
  localparam logic [2:0] c_ALU_ANDI = 3'd4;

  typedef enum logic [2:0] {
    S_INIT   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_EXEC2  = 3'd4,
    S_HALT   = 3'd5
  } state_e;

  state_e     state_q;
  state_e     state_d;
  logic [3:0] w_opcode;
  logic       w_br_taken;

  assign w_opcode   = bus.ir[15:12];
  assign w_br_taken = (bus.ir[11] & bus.n) | (bus.ir[10] & bus.z) | (bus.ir[9] & bus.p);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_INIT;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d              = state_q;
    bus.mem_w_en         = 1'b0;
    bus.mem_w_addr_sel   = 2'd0;
    bus.mem_w_data_sel   = 1'b0;
    bus.mem_r_addr_sel   = 2'd0;
    bus.rf_w_en          = 1'b0;
    bus.rf_r0_addr_sel   = 1'b0;
    bus.rf_r1_addr_sel   = 1'b0;
    bus.rf_w_data_sel    = 2'd0;
    bus.rf_w_addr_sel    = 1'b0;
    bus.ir_ld            = 1'b0;
    bus.pc_ld            = 1'b0;
    bus.pc_clr           = 1'b0;
    bus.pc_inc           = 1'b0;
    bus.pc_ld_data_sel   = 2'd0;
    bus.alu_sel          = 3'd0;
    bus.cond_ld          = 1'b0;
    bus.cond_ld_data_sel = 1'b0;
    bus.ldi_reg_ld       = 1'b0;
    bus.halted           = 1'b0;

    unique case (state_q)
      S_INIT: begin
        bus.pc_clr = 1'b1;
        state_d    = S_FETCH;
      end
      S_FETCH: begin
        bus.ir_ld  = 1'b1;
        bus.pc_inc = 1'b1;
        state_d    = S_DECODE;
      end
      S_DECODE: begin
        state_d = (w_opcode == HALT_OPCODE) ? S_HALT : S_EXEC;
      end
      S_EXEC: begin
        state_d = S_FETCH;
        case (w_opcode)
          c_OP_ADD, c_OP_AND: begin
            if (w_opcode == c_OP_ADD) bus.alu_sel = bus.ir[5] ? c_ALU_ADDI : c_ALU_ADD;
            else                      bus.alu_sel = bus.ir[5] ? c_ALU_ANDI : c_ALU_AND;
            bus.rf_w_en = 1'b1;
            bus.cond_ld = 1'b1;
          end
          c_OP_NOT: begin
            bus.alu_sel = c_ALU_NOT;
            bus.rf_w_en = 1'b1;
            bus.cond_ld = 1'b1;
          end
          c_OP_BR: begin
            bus.pc_ld = w_br_taken;
          end
          c_OP_JMP: begin
            bus.pc_ld          = 1'b1;
            bus.pc_ld_data_sel = 2'd1;
          end
          c_OP_JSR: begin
            // R7 captures the already-incremented PC on the same edge PC jumps
            bus.rf_w_en        = 1'b1;
            bus.rf_w_addr_sel  = 1'b1;
            bus.rf_w_data_sel  = 2'd2;
            bus.pc_ld          = 1'b1;
            bus.pc_ld_data_sel = bus.ir[11] ? 2'd2 : 2'd1;
          end
          c_OP_LD, c_OP_LDR: begin
            bus.mem_r_addr_sel   = (w_opcode == c_OP_LD) ? 2'd1 : 2'd2;
            bus.rf_w_en          = 1'b1;
            bus.rf_w_data_sel    = 2'd1;
            bus.cond_ld          = 1'b1;
            bus.cond_ld_data_sel = 1'b1;
          end
          c_OP_LEA: begin
            bus.rf_w_en          = 1'b1;
            bus.rf_w_data_sel    = 2'd3;
            bus.cond_ld          = 1'b1;
            bus.cond_ld_data_sel = 1'b1;
          end
          c_OP_ST, c_OP_STR: begin
            bus.mem_w_en       = 1'b1;
            bus.mem_w_addr_sel = (w_opcode == c_OP_ST) ? 2'd0 : 2'd1;
            bus.rf_r0_addr_sel = 1'b1;
            bus.rf_r1_addr_sel = (w_opcode == c_OP_STR);
          end
          c_OP_STI: begin
            bus.mem_r_addr_sel = 2'd1;
            bus.mem_w_en       = 1'b1;
            bus.mem_w_addr_sel = 2'd2;
            bus.rf_r0_addr_sel = 1'b1;
          end
          c_OP_LDI: begin
            bus.mem_r_addr_sel = 2'd1;
            bus.ldi_reg_ld     = 1'b1;
            state_d            = S_EXEC2;
          end
          default: ;
        endcase
      end
      S_EXEC2: begin
        bus.mem_r_addr_sel   = 2'd3;
        bus.rf_w_en          = 1'b1;
        bus.rf_w_data_sel    = 2'd1;
        bus.cond_ld          = 1'b1;
        bus.cond_ld_data_sel = 1'b1;
        state_d              = S_FETCH;
      end
      S_HALT: begin
        bus.halted = 1'b1;
      end
      default: state_d = S_INIT;
    endcase
  end

`ifdef PUNC_CTRL_PERF_EN
  logic [15:0] retired_q;
  logic        w_retire;

  assign w_retire = ((state_q == S_EXEC) || (state_q == S_EXEC2)) && (state_d == S_FETCH);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          retired_q <= 16'd0;
    else if (w_retire) retired_q <= retired_q + 16'd1;
  end

  assign instr_retired = retired_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_punc_control.sv
// ============================================================================
//  tb_punc_control : table-driven, scoreboarded bench for punc_control.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_punc_control;

  typedef struct packed {
    logic       mem_w_en;
    logic [1:0] mem_w_addr_sel;
    logic       mem_w_data_sel;
    logic [1:0] mem_r_addr_sel;
    logic       rf_w_en;
    logic       rf_r0_addr_sel;
    logic       rf_r1_addr_sel;
    logic [1:0] rf_w_data_sel;
    logic       rf_w_addr_sel;
    logic       ir_ld;
    logic       pc_ld;
    logic       pc_clr;
    logic       pc_inc;
    logic [1:0] pc_ld_data_sel;
    logic [2:0] alu_sel;
    logic       cond_ld;
    logic       cond_ld_data_sel;
    logic       ldi_reg_ld;
    logic       halted;
  } ctrl_t;

  typedef struct {
    logic [15:0] ir;
    logic [2:0]  nzp;
    logic        two;
    ctrl_t       e1;
    ctrl_t       e2;
  } vec_t;

  localparam int c_NVEC = 21;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   exp_retired = 0;
  ctrl_t sb_q[$];
  vec_t  vecs[c_NVEC];

  punc_control_if bus ();

`ifdef PUNC_CTRL_PERF_EN
  logic [15:0] instr_retired;
  punc_control dut (.clk(clk), .rst(rst), .bus(bus.master), .instr_retired(instr_retired));
`else
  punc_control dut (.clk(clk), .rst(rst), .bus(bus.master));
`endif

  always #5 clk = ~clk;

  function automatic ctrl_t sample();
    ctrl_t a;
    a.mem_w_en         = bus.mem_w_en;
    a.mem_w_addr_sel   = bus.mem_w_addr_sel;
    a.mem_w_data_sel   = bus.mem_w_data_sel;
    a.mem_r_addr_sel   = bus.mem_r_addr_sel;
    a.rf_w_en          = bus.rf_w_en;
    a.rf_r0_addr_sel   = bus.rf_r0_addr_sel;
    a.rf_r1_addr_sel   = bus.rf_r1_addr_sel;
    a.rf_w_data_sel    = bus.rf_w_data_sel;
    a.rf_w_addr_sel    = bus.rf_w_addr_sel;
    a.ir_ld            = bus.ir_ld;
    a.pc_ld            = bus.pc_ld;
    a.pc_clr           = bus.pc_clr;
    a.pc_inc           = bus.pc_inc;
    a.pc_ld_data_sel   = bus.pc_ld_data_sel;
    a.alu_sel          = bus.alu_sel;
    a.cond_ld          = bus.cond_ld;
    a.cond_ld_data_sel = bus.cond_ld_data_sel;
    a.ldi_reg_ld       = bus.ldi_reg_ld;
    a.halted           = bus.halted;
    return a;
  endfunction

  task automatic check(input string name, input ctrl_t exp);
    ctrl_t act;
    act = sample();
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic ctrl_t c_init();
    ctrl_t e = '0;
    e.pc_clr = 1'b1;
    return e;
  endfunction

  function automatic ctrl_t c_fetch();
    ctrl_t e = '0;
    e.ir_ld  = 1'b1;
    e.pc_inc = 1'b1;
    return e;
  endfunction

  function automatic ctrl_t c_alu(input logic [2:0] sel);
    ctrl_t e = '0;
    e.alu_sel = sel;
    e.rf_w_en = 1'b1;
    e.cond_ld = 1'b1;
    return e;
  endfunction

  function automatic ctrl_t c_load(input logic [1:0] rsel, input logic [1:0] wdata);
    ctrl_t e = '0;
    e.mem_r_addr_sel   = rsel;
    e.rf_w_en          = 1'b1;
    e.rf_w_data_sel    = wdata;
    e.cond_ld          = 1'b1;
    e.cond_ld_data_sel = 1'b1;
    return e;
  endfunction

  function automatic ctrl_t c_store(input logic [1:0] wsel, input logic r1, input logic [1:0] rsel);
    ctrl_t e = '0;
    e.mem_w_en       = 1'b1;
    e.mem_w_addr_sel = wsel;
    e.rf_r0_addr_sel = 1'b1;
    e.rf_r1_addr_sel = r1;
    e.mem_r_addr_sel = rsel;
    return e;
  endfunction

  function automatic ctrl_t c_pc(input logic ld, input logic [1:0] sel, input logic link);
    ctrl_t e = '0;
    e.pc_ld          = ld;
    e.pc_ld_data_sel = sel;
    e.rf_w_en        = link;
    e.rf_w_addr_sel  = link;
    e.rf_w_data_sel  = link ? 2'd2 : 2'd0;
    return e;
  endfunction

  // Bounded wait for the FETCH cycle (sampled mid-cycle on the falling edge)
  task automatic wait_fetch();
    for (int i = 0; i < 10; i++) begin
      if (bus.ir_ld === 1'b1) return;
      @(negedge clk);
    end
    checks++;
    errors++;
    $display("FAIL wait_fetch: got no ir_ld within 10 cycles, required ir_ld=1");
  endtask

  task automatic run_vec(input int idx);
    ctrl_t zero = '0;
    wait_fetch();
    bus.ir = vecs[idx].ir;
    {bus.n, bus.z, bus.p} = vecs[idx].nzp;
    sb_q.push_back(vecs[idx].e1);
    if (vecs[idx].two) sb_q.push_back(vecs[idx].e2);
    @(negedge clk);
    check($sformatf("decode_%0d", idx), zero);
    @(negedge clk);
    check($sformatf("exec_%0d", idx), sb_q.pop_front());
    if (vecs[idx].two) begin
      @(negedge clk);
      check($sformatf("exec2_%0d", idx), sb_q.pop_front());
    end
    exp_retired++;
    @(negedge clk);
  endtask

  task automatic release_reset();
    rst = 1'b1;
    #1;
    check("init_after_release", c_init());
    @(negedge clk);
    check("first_fetch", c_fetch());
  endtask

  initial begin
    ctrl_t e;
    bus.ir = 16'h0000;
    bus.n  = 1'b0;
    bus.z  = 1'b0;
    bus.p  = 1'b0;

    vecs[0]  = '{16'h1261, 3'b000, 1'b0, c_alu(3'd1), '0};
    vecs[1]  = '{16'h1042, 3'b000, 1'b0, c_alu(3'd0), '0};
    vecs[2]  = '{16'h5240, 3'b000, 1'b0, c_alu(3'd3), '0};
    vecs[3]  = '{16'h5263, 3'b000, 1'b0, c_alu(3'd4), '0};
    vecs[4]  = '{16'h927F, 3'b000, 1'b0, c_alu(3'd2), '0};
    vecs[5]  = '{16'h0402, 3'b010, 1'b0, c_pc(1'b1, 2'd0, 1'b0), '0};
    vecs[6]  = '{16'h0402, 3'b100, 1'b0, c_pc(1'b0, 2'd0, 1'b0), '0};
    vecs[7]  = '{16'h0002, 3'b111, 1'b0, c_pc(1'b0, 2'd0, 1'b0), '0};
    vecs[8]  = '{16'h0E05, 3'b001, 1'b0, c_pc(1'b1, 2'd0, 1'b0), '0};
    vecs[9]  = '{16'hC1C0, 3'b000, 1'b0, c_pc(1'b1, 2'd1, 1'b0), '0};
    vecs[10] = '{16'h4802, 3'b000, 1'b0, c_pc(1'b1, 2'd2, 1'b1), '0};
    vecs[11] = '{16'h4080, 3'b000, 1'b0, c_pc(1'b1, 2'd1, 1'b1), '0};
    vecs[12] = '{16'h2205, 3'b000, 1'b0, c_load(2'd1, 2'd1), '0};
    vecs[13] = '{16'h6285, 3'b000, 1'b0, c_load(2'd2, 2'd1), '0};
    vecs[14] = '{16'hE405, 3'b000, 1'b0, c_load(2'd0, 2'd3), '0};
    vecs[15] = '{16'h3205, 3'b000, 1'b0, c_store(2'd0, 1'b0, 2'd0), '0};
    vecs[16] = '{16'h7285, 3'b000, 1'b0, c_store(2'd1, 1'b1, 2'd0), '0};
    vecs[17] = '{16'hB205, 3'b000, 1'b0, c_store(2'd2, 1'b0, 2'd1), '0};
    e = '0; e.mem_r_addr_sel = 2'd1; e.ldi_reg_ld = 1'b1;
    vecs[18] = '{16'hA003, 3'b000, 1'b1, e, c_load(2'd3, 2'd1)};
    vecs[19] = '{16'h8000, 3'b111, 1'b0, '0, '0};
    vecs[20] = '{16'hD000, 3'b111, 1'b0, '0, '0};

    // Reset held: INIT outputs visible while rst is low
    repeat (2) @(negedge clk);
    check("reset_state", c_init());
`ifdef PUNC_CTRL_PERF_EN
    checks++;
    if (instr_retired !== 16'd0) begin
      errors++;
      $display("FAIL perf_reset: got %0d expected 0", instr_retired);
    end
`endif
    release_reset();

    for (int i = 0; i < c_NVEC; i++) run_vec(i);

`ifdef PUNC_CTRL_PERF_EN
    checks++;
    if (instr_retired !== 16'(exp_retired)) begin
      errors++;
      $display("FAIL perf_count: got %0d expected %0d", instr_retired, exp_retired);
    end
`endif

    // Asynchronous reset in the middle of EXEC2
    wait_fetch();
    bus.ir = 16'hA003;
    repeat (3) @(negedge clk);
    check("ldi_exec2_before_reset", vecs[18].e2);
    rst = 1'b0;
    #1;
    check("async_reset_mid_exec2", c_init());
    exp_retired = 0;
    @(negedge clk);
    release_reset();

    run_vec(0);
    run_vec(2);

    // HALT: terminal, no strobes, counter frozen
    wait_fetch();
    bus.ir = 16'hF025;
    @(negedge clk);
    check("halt_decode", '0);
    e = '0;
    e.halted = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      check($sformatf("halt_cycle_%0d", i), e);
`ifdef PUNC_CTRL_PERF_EN
      checks++;
      if (instr_retired !== 16'(exp_retired)) begin
        errors++;
        $display("FAIL perf_halt_%0d: got %0d expected %0d", i, instr_retired, exp_retired);
      end
`endif
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, required completion");
    $fatal(1);
  end

endmodule

`default_nettype wire
